// File: rtl/riscv_1stage_fetch_pkg.sv
// riscv_1stage_fetch_pkg: shared 1-stage next-PC select encodings and fetch constants
package riscv_1stage_fetch_pkg;
  typedef enum logic [2:0] {
    pc_sel_pc_4      = 3'd0,
    pc_sel_branch    = 3'd1,
    pc_sel_jump      = 3'd2,
    pc_sel_jalr      = 3'd3,
    pc_sel_exception = 3'd4
  } pc_sel_e;
  localparam logic [31:0] NOP = 32'h0000_0013;
endpackage

// File: rtl/riscv_1stage_fetch_if.sv
// riscv_1stage_fetch_if: instruction-memory request/response bus
interface riscv_1stage_fetch_if;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemReady;
  logic [31:0] imemData;
  modport master (output imemReq, imemAddr, input imemReady, imemData);
  modport slave (input imemReq, imemAddr, output imemReady, imemData);
endinterface

// File: rtl/riscv_1stage_next_pc.sv
// riscv_1stage_next_pc: next-PC mux with misaligned-target redirect to the exception vector
module riscv_1stage_next_pc
  import riscv_1stage_fetch_pkg::*;
#(
  parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_0100
) (
  input  logic [31:0] pc_i,
  input  logic [2:0]  sel_i,
  input  logic [31:0] branch_i,
  input  logic [31:0] jump_i,
  input  logic [31:0] jalr_i,
  output logic [31:0] next_pc_o,
  output logic        misaligned_o
);
  logic [31:0] target;
  always_comb begin
    target = sel_i == pc_sel_pc_4   ? pc_i + 32'd4 :
             sel_i == pc_sel_branch ? branch_i :
             sel_i == pc_sel_jump   ? jump_i :
             sel_i == pc_sel_jalr   ? {jalr_i[31:1], 1'b0} : EXCEPTION_VECTOR;
    misaligned_o = |target[1:0];
    next_pc_o = misaligned_o ? EXCEPTION_VECTOR : target;
  end
endmodule

// File: rtl/riscv_1stage_fetch.sv
// riscv_1stage_fetch: FETCH/HOLD instruction fetch unit with next-PC select and retire counter
module riscv_1stage_fetch
  import riscv_1stage_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter logic [31:0] EXCEPTION_VECTOR = 32'h0000_0100
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [2:0]                 pcSelect,
  input  logic [31:0]                branchTarget,
  input  logic [31:0]                jumpTarget,
  input  logic [31:0]                jalrTarget,
  input  logic                       retire,
  riscv_1stage_fetch_if.master       imem,
  output logic [31:0]                instruction,
  output logic [31:0]                pc,
  output logic [31:0]                pcPlus4,
  output logic                       instructionValid,
  output logic                       misaligned,
  output logic [31:0]                instret
);
  typedef enum logic {FETCH, HOLD} state_e;
  state_e      state_q;
  logic [31:0] pc_q, instr_q, instret_q, pc_d;
  logic        misaligned_q, misaligned_d;
  riscv_1stage_next_pc #(.EXCEPTION_VECTOR(EXCEPTION_VECTOR)) u_next_pc (
    .pc_i(pc_q),
    .sel_i(pcSelect),
    .branch_i(branchTarget),
    .jump_i(jumpTarget),
    .jalr_i(jalrTarget),
    .next_pc_o(pc_d),
    .misaligned_o(misaligned_d)
  );
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FETCH;
      pc_q <= RESET_PC;
      instr_q <= NOP;
      instret_q <= '0;
      misaligned_q <= 1'b0;
    end else if (state_q == FETCH) begin
      if (imem.imemReady) begin
        instr_q <= imem.imemData;
        state_q <= HOLD;
      end
    end else if (retire) begin
      pc_q <= pc_d;
      instret_q <= instret_q + 32'd1;
      misaligned_q <= misaligned_q | misaligned_d;
      state_q <= FETCH;
    end
  end
  assign imem.imemReq = state_q == FETCH;
  assign imem.imemAddr = pc_q;
  assign instructionValid = state_q == HOLD;
  assign instruction = instr_q;
  assign pc = pc_q;
  assign pcPlus4 = pc_q + 32'd4;
  assign misaligned = misaligned_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_riscv_1stage_fetch.sv
// tb_riscv_1stage_fetch: randomized self-checking bench against a behavioural fetch model
module tb_riscv_1stage_fetch;
  localparam logic [31:0] EV = 32'h0000_0100;
  logic clk = 1'b0, rst = 1'b1;
  logic [2:0] pcSelect = '0;
  logic [31:0] branchTarget = '0, jumpTarget = '0, jalrTarget = '0;
  logic retire = 1'b0;
  logic [31:0] instruction, pc, pcPlus4, instret;
  logic instructionValid, misaligned;
  int checks = 0, failures = 0;
  logic [31:0] m_pc, m_instr, m_instret;
  logic m_mis;
  always #5 clk = ~clk;
  riscv_1stage_fetch_if imem ();
  riscv_1stage_fetch dut (
    .clk(clk), .rst(rst), .pcSelect(pcSelect), .branchTarget(branchTarget),
    .jumpTarget(jumpTarget), .jalrTarget(jalrTarget), .retire(retire), .imem(imem),
    .instruction(instruction), .pc(pc), .pcPlus4(pcPlus4),
    .instructionValid(instructionValid), .misaligned(misaligned), .instret(instret)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
  endfunction
  function automatic void model_reset();
    m_pc = 32'h0; m_instr = 32'h13; m_instret = 0; m_mis = 1'b0;
  endfunction
  function automatic void model_retire(input logic [2:0] s, input logic [31:0] b, j, r);
    logic [31:0] t;
    case (s)
      3'd0: t = m_pc + 32'd4;
      3'd1: t = b;
      3'd2: t = j;
      3'd3: t = r & ~32'd1;
      default: t = EV;
    endcase
    if (t % 4 != 0) begin
      t = EV;
      m_mis = 1'b1;
    end
    m_pc = t;
    m_instret = m_instret + 32'd1;
  endfunction
  task automatic do_fetch(input int wt);
    imem.imemReady = 1'b0;
    repeat (wt) @(negedge clk);
    imem.imemReady = 1'b1;
    imem.imemData = mem(m_pc);
    @(negedge clk);
    imem.imemReady = 1'b0;
    imem.imemData = $urandom;
    m_instr = mem(m_pc);
  endtask
  task automatic do_retire(input logic [2:0] s, input logic [31:0] b, j, r);
    pcSelect = s; branchTarget = b; jumpTarget = j; jalrTarget = r; retire = 1'b1;
    model_retire(s, b, j, r);
    @(negedge clk);
    retire = 1'b0;
    pcSelect = 3'($urandom); branchTarget = $urandom; jumpTarget = $urandom; jalrTarget = $urandom;
  endtask
  task automatic test_reset();
    imem.imemReady = 1'b0; imem.imemData = '0;
    model_reset();
    @(negedge clk);
    checks++;
    if (instructionValid !== 1'b0 || pc !== 32'h0 || instret !== 32'h0 || misaligned !== 1'b0 || instruction !== 32'h13 || imem.imemReq !== 1'b1) begin
      failures++;
      $display("FAIL reset: valid=%b pc=%h instret=%h mis=%b instr=%h req=%b, required 0/0/0/0/00000013/1", instructionValid, pc, instret, misaligned, instruction, imem.imemReq);
    end
    rst = 1'b0;
  endtask
  task automatic test_first_fetch();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (imem.imemReq !== 1'b1 || imem.imemAddr !== 32'h0 || instructionValid !== 1'b0) begin
        failures++;
        $display("FAIL first_fetch_wait%0d: req=%b addr=%h valid=%b, required 1/00000000/0", i, imem.imemReq, imem.imemAddr, instructionValid);
      end
      if (i == 2) begin
        imem.imemReady = 1'b1; imem.imemData = 32'h93;
      end
      @(negedge clk);
    end
    imem.imemReady = 1'b0;
    m_instr = 32'h93;
    checks++;
    if (instructionValid !== 1'b1 || instruction !== 32'h93 || pc !== 32'h0 || pcPlus4 !== 32'h4 || imem.imemReq !== 1'b0) begin
      failures++;
      $display("FAIL first_fetch_hold: valid=%b instr=%h pc=%h pc4=%h req=%b, required 1/00000093/0/4/0", instructionValid, instruction, pc, pcPlus4, imem.imemReq);
    end
    do_retire(3'd0, 0, 0, 0);
  endtask
  task automatic test_branch();
    repeat (3) begin
      do_fetch(0);
      do_retire(3'd0, 0, 0, 0);
    end
    do_fetch(1);
    checks++;
    if (pc !== 32'h10 || instruction !== mem(32'h10)) begin
      failures++;
      $display("FAIL branch_setup: pc=%h instr=%h, required 00000010/%h", pc, instruction, mem(32'h10));
    end
    do_retire(3'd1, 32'h40, $urandom, $urandom);
    checks++;
    if (imem.imemAddr !== 32'h40 || instret !== m_instret || instret !== 32'd5 || instructionValid !== 1'b0) begin
      failures++;
      $display("FAIL branch: addr=%h instret=%0d valid=%b, required 00000040/%0d/0", imem.imemAddr, instret, instructionValid, m_instret);
    end
  endtask
  task automatic test_jalr();
    do_fetch(0);
    do_retire(3'd3, $urandom, $urandom, 32'h201);
    checks++;
    if (pc !== 32'h200 || misaligned !== 1'b0) begin
      failures++;
      $display("FAIL jalr_bit0: pc=%h mis=%b, required 00000200/0", pc, misaligned);
    end
    do_fetch(0);
    do_retire(3'd3, $urandom, $urandom, 32'h202);
    checks++;
    if (pc !== EV || misaligned !== 1'b1) begin
      failures++;
      $display("FAIL jalr_misaligned: pc=%h mis=%b, required %h/1", pc, misaligned, EV);
    end
    do_fetch(0);
    do_retire(3'd0, 0, 0, 0);
    checks++;
    if (pc !== EV + 32'd4 || misaligned !== 1'b1) begin
      failures++;
      $display("FAIL misaligned_sticky: pc=%h mis=%b, required %h/1", pc, misaligned, EV + 32'd4);
    end
  endtask
  task automatic test_illegal_select();
    logic [2:0] sels [3] = '{3'd6, 3'd4, 3'd7};
    for (int i = 0; i < 3; i++) begin
      do_fetch(0);
      do_retire(3'd2, 0, 32'h80 + 32'(i) * 4, 0);
      do_fetch(0);
      do_retire(sels[i], $urandom & ~32'd3, $urandom & ~32'd3, $urandom & ~32'd3);
      checks++;
      if (pc !== EV || pc !== m_pc) begin
        failures++;
        $display("FAIL select_%0d: pc=%h, required %h", sels[i], pc, EV);
      end
    end
  endtask
  task automatic test_wrap();
    do_fetch(0);
    do_retire(3'd2, 0, 32'hFFFF_FFFC, 0);
    do_fetch(2);
    checks++;
    if (pc !== 32'hFFFF_FFFC || pcPlus4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pcplus4: pc=%h pc4=%h, required fffffffc/00000000", pc, pcPlus4);
    end
    do_retire(3'd0, 0, 0, 0);
    checks++;
    if (pc !== 32'h0 || imem.imemAddr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_pc: pc=%h addr=%h, required 00000000/00000000", pc, imem.imemAddr);
    end
  endtask
  task automatic test_stall();
    do_fetch(1);
    for (int i = 0; i < 5; i++) begin
      imem.imemReady = 1'($urandom);
      imem.imemData = $urandom;
      @(negedge clk);
      checks++;
      if (instructionValid !== 1'b1 || instruction !== m_instr || pc !== m_pc || instret !== m_instret || imem.imemReq !== 1'b0) begin
        failures++;
        $display("FAIL stall%0d: valid=%b instr=%h pc=%h instret=%0d, required 1/%h/%h/%0d", i, instructionValid, instruction, pc, instret, m_instr, m_pc, m_instret);
      end
    end
    imem.imemReady = 1'b0;
    do_retire(3'd0, 0, 0, 0);
  endtask
  task automatic test_reset_mid();
    do_fetch(0);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (pc !== 32'h0 || instret !== 32'h0 || instructionValid !== 1'b0 || misaligned !== 1'b0 || instruction !== 32'h13) begin
      failures++;
      $display("FAIL reset_hold: pc=%h instret=%0d valid=%b mis=%b instr=%h, required 0/0/0/0/00000013", pc, instret, instructionValid, misaligned, instruction);
    end
    @(negedge clk);
    rst = 1'b0;
    do_fetch(0);
    do_retire(3'd2, 0, 32'h300, 0);
    imem.imemReady = 1'b0;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    model_reset();
    checks++;
    if (pc !== 32'h0 || instret !== 32'h0 || instructionValid !== 1'b0 || imem.imemReq !== 1'b1) begin
      failures++;
      $display("FAIL reset_fetch: pc=%h instret=%0d valid=%b req=%b, required 0/0/0/1", pc, instret, instructionValid, imem.imemReq);
    end
    @(negedge clk);
    rst = 1'b0;
    do_fetch(0);
    checks++;
    if (instructionValid !== 1'b1 || instruction !== mem(32'h0) || pc !== 32'h0) begin
      failures++;
      $display("FAIL reset_release_response: valid=%b instr=%h pc=%h, required 1/%h/0", instructionValid, instruction, pc, mem(32'h0));
    end
    do_retire(3'd0, 0, 0, 0);
  endtask
  task automatic test_random();
    logic [31:0] t [3];
    for (int n = 0; n < 60; n++) begin
      do_fetch($urandom_range(0, 3));
      checks++;
      if (instructionValid !== 1'b1 || instruction !== m_instr || pc !== m_pc || pcPlus4 !== m_pc + 32'd4) begin
        failures++;
        $display("FAIL rand_fetch%0d: valid=%b instr=%h pc=%h pc4=%h, required 1/%h/%h/%h", n, instructionValid, instruction, pc, pcPlus4, m_instr, m_pc, m_pc + 32'd4);
      end
      for (int k = 0; k < 3; k++) begin
        t[k] = $urandom & ~32'd3;
        if ($urandom_range(0, 9) == 0) t[k] = t[k] | 32'($urandom_range(1, 3));
      end
      do_retire(3'($urandom_range(0, 7)), t[0], t[1], t[2]);
      checks++;
      if (pc !== m_pc || imem.imemAddr !== m_pc || misaligned !== m_mis || instret !== m_instret || instructionValid !== 1'b0) begin
        failures++;
        $display("FAIL rand_retire%0d: pc=%h addr=%h mis=%b instret=%0d valid=%b, required %h/%h/%b/%0d/0", n, pc, imem.imemAddr, misaligned, instret, instructionValid, m_pc, m_pc, m_mis, m_instret);
      end
    end
  endtask
  initial begin
    test_reset();
    test_first_fetch();
    test_branch();
    test_jalr();
    test_illegal_select();
    test_wrap();
    test_stall();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/riscv_1stage_fetch.md
RISCV_1STAGE_FETCH -- requirements
Module: riscv_1stage_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, the first fetch address after reset.
REQ-002 SHALL have parameter EXCEPTION_VECTOR, default 32'h0000_0100, the redirect address for exception or illegal selects.
REQ-003 SHALL have port clk, input, 1, the only clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; asynchronous and active-high.
REQ-005 SHALL have port pcSelect, input, 3, next-PC select from the control decoder.
REQ-006 SHALL have ports branchTarget, jumpTarget and jalrTarget, input, 32 each, the redirect targets computed by the datapath.
REQ-007 SHALL have port retire, input, 1, the datapath commits the held instruction this cycle.
REQ-008 SHALL have ports imemReq (output, 1) and imemAddr (output, 32), the instruction-memory request and its word address.
REQ-009 SHALL have ports imemReady (input, 1) and imemData (input, 32), the memory response strobe and its data.
REQ-010 SHALL have ports instruction (output, 32), pc (output, 32) and pcPlus4 (output, 32), the held instruction, its address, and that address plus 4.
REQ-011 SHALL have port instructionValid, output, 1, high when instruction is held for decode.
REQ-012 SHALL have port misaligned, output, 1, a sticky flag set by a misaligned redirect.
REQ-013 SHALL have port instret, output, 32, the count of retired instructions.

Function
REQ-014 SHALL implement a two-state FSM, FETCH and HOLD; reset enters FETCH.
REQ-015 In FETCH: imemReq=1, imemAddr=pc, instructionValid=0; retire is ignored.
REQ-016 In FETCH, when imemReady=1, SHALL latch imemData into instruction and enter HOLD on the same edge.
REQ-017 instructionValid SHALL be 1 exactly while in HOLD, i.e. one cycle after the imemReady edge; imemReq=0 in HOLD.
REQ-018 In HOLD with retire=1, SHALL load pc with the next PC, increment instret, and return to FETCH; with retire=0, all state SHALL hold.
REQ-019 Next PC SHALL be selected by pcSelect as follows:
- 0 (pc_4): pc+4.
- 1 (branch): branchTarget.
- 2 (jump): jumpTarget.
- 3 (jalr): jalrTarget with bit0 cleared.
- 4 (exception): EXCEPTION_VECTOR.
- 5-7: EXCEPTION_VECTOR.
REQ-020 If the selected target (after jalr bit0 clear) has bits[1:0]!=0, next PC SHALL be EXCEPTION_VECTOR and misaligned SHALL set; misaligned clears only on reset.
REQ-021 All PC arithmetic SHALL be modulo 2^32; pc=32'hFFFF_FFFC with pc_4 wraps to 0; pcPlus4 wraps identically.
REQ-022 instret SHALL wrap from 32'hFFFF_FFFF to 0.
REQ-023 Minimum throughput SHALL be one instruction per 2 cycles (imemReady on the first FETCH cycle, retire on the first HOLD cycle).
REQ-024 pcSelect and the target inputs SHALL be sampled only on the retire edge; they are don't-care otherwise.
REQ-025 imemReady outside FETCH SHALL be ignored and SHALL NOT alter instruction.

Reset
REQ-026 On rst=1, regardless of clock and mid-transaction, SHALL set state=FETCH, pc=RESET_PC, instruction=32'h0000_0013 (NOP), misaligned=0 and instret=0.
REQ-027 A memory response arriving in the cycle reset deasserts SHALL be treated as a normal FETCH response for RESET_PC.

Structure
REQ-028 The pcSelect encodings (pc_sel_pc_4/branch/jump/jalr/exception = 0..4) SHALL come from the shared 1-stage selections package; the FSM state constants SHALL be local.
REQ-029 The next-PC mux and misalignment check SHALL be one combinational sub-module, riscv_1stage_next_pc.

Verification
REQ-030 Reset with RESET_PC=0, memory returns 32'h0000_0093 after 2 wait cycles -> imemReq high for 3 cycles, then instructionValid=1, instruction=32'h0000_0093, pc=0, pcPlus4=4.
REQ-031 pc=0x10, pcSelect=1, branchTarget=0x40, retire -> next imemAddr=0x40, instret increments by 1.
REQ-032 pcSelect=3, jalrTarget=0x0000_0201, retire -> pc=0x200, misaligned=0; with jalrTarget=0x202 -> pc=0x100, misaligned=1.
REQ-033 pcSelect=6, retire -> pc=0x100; pc=0xFFFF_FFFC, pcSelect=0, retire -> pc=0.
REQ-034 Hold retire=0 for 5 HOLD cycles -> outputs stable; assert rst during FETCH wait -> pc=RESET_PC, instret=0, instructionValid=0 immediately.
